// File: rtl/l2_fmap_stream_buffer_if.sv
// Bus bundle for the layer-2 feature-map stream buffer: per-channel write ports,
// downstream engine handshakes and the lockstep replay stream.
interface l2_fmap_stream_buffer_if #(
    parameter int unsigned NUM_CH  = 6,
    parameter int unsigned NUM_OUT = 16
);
    logic [NUM_CH-1:0]   wr_valid;
    logic [NUM_CH*8-1:0] wr_pixel;
    logic [NUM_OUT-1:0]  ds_loading_done;
    logic [NUM_OUT-1:0]  ds_layer_done;
    logic                ds_start;
    logic [NUM_CH-1:0]   data_valid_out;
    logic [NUM_CH*8-1:0] pixel_out;
    logic                busy;
    logic                frame_done;
    logic                overflow;

    modport master (
        output wr_valid, wr_pixel, ds_loading_done, ds_layer_done,
        input  ds_start, data_valid_out, pixel_out, busy, frame_done, overflow
    );

    modport slave (
        input  wr_valid, wr_pixel, ds_loading_done, ds_layer_done,
        output ds_start, data_valid_out, pixel_out, busy, frame_done, overflow
    );
endinterface

// File: rtl/l2_fmap_stream_buffer.sv
// Captures NUM_CH independent layer-1 map streams into RAM, then replays them as
// lockstep raster streams broadcast to the layer-2 engines once all are ready.
module l2_fmap_stream_buffer #(
    parameter int unsigned MAPSIZE = 14,
    parameter int unsigned NUM_CH  = 6,
    parameter int unsigned NUM_OUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    l2_fmap_stream_buffer_if.slave bus
);
    localparam int unsigned MAP_PIX = MAPSIZE * MAPSIZE;
    localparam int unsigned CNT_W   = $clog2(MAP_PIX + 1);
    localparam int unsigned ADDR_W  = $clog2(MAP_PIX);

    typedef enum logic [2:0] {
        ST_FILL,
        ST_WAIT_LOAD,
        ST_START,
        ST_STREAM,
        ST_DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [7:0]          mem_q [NUM_CH][MAP_PIX];
    logic [CNT_W-1:0]    wr_cnt_q [NUM_CH];
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [NUM_OUT-1:0]  lay_done_flg_q, lay_done_flg_d;

    logic                ds_start_q;
    logic                valid_q;
    logic [NUM_CH*8-1:0] pixel_q;
    logic                busy_q;
    logic                frame_done_q;
    logic                overflow_q;

    logic [NUM_CH-1:0]   lane_full_c;
    logic [NUM_CH-1:0]   wr_accept_c;
    logic                all_full_c;
    logic                all_loaded_c;
    logic                issue_c;
    logic                frame_end_c;

    // Per-lane write acceptance: only in FILL and only while the lane has room.
    always_comb begin
        lane_full_c = '0;
        wr_accept_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            lane_full_c[i] = (wr_cnt_q[i] == CNT_W'(MAP_PIX));
            wr_accept_c[i] = bus.wr_valid[i] && (state_q == ST_FILL) && !lane_full_c[i];
        end
    end

    assign all_full_c   = &lane_full_c;
    assign all_loaded_c = &bus.ds_loading_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_FILL;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FILL:      if (all_full_c)   state_d = ST_WAIT_LOAD;
            ST_WAIT_LOAD: if (all_loaded_c) state_d = ST_START;
            ST_START:                       state_d = ST_STREAM;
            ST_STREAM:    if (rd_addr_q == ADDR_W'(MAP_PIX - 1)) state_d = ST_DRAIN;
            ST_DRAIN:     if (&lay_done_flg_d) state_d = ST_FILL;
            default:                        state_d = ST_FILL;
        endcase
    end

    // Datapath controls; layer-done pulses are accumulated from STREAM onward.
    always_comb begin
        rd_addr_d      = rd_addr_q;
        lay_done_flg_d = lay_done_flg_q;
        issue_c        = 1'b0;
        frame_end_c    = 1'b0;
        unique case (state_q)
            ST_START: begin
                rd_addr_d      = '0;
                lay_done_flg_d = '0;
            end
            ST_STREAM: begin
                issue_c        = 1'b1;
                rd_addr_d      = rd_addr_q + ADDR_W'(1);
                lay_done_flg_d = lay_done_flg_q | bus.ds_layer_done;
            end
            ST_DRAIN: begin
                lay_done_flg_d = lay_done_flg_q | bus.ds_layer_done;
                frame_end_c    = &lay_done_flg_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr_q      <= '0;
            lay_done_flg_q <= '0;
            for (int i = 0; i < NUM_CH; i++) wr_cnt_q[i] <= '0;
        end else begin
            rd_addr_q      <= rd_addr_d;
            lay_done_flg_q <= lay_done_flg_d;
            for (int i = 0; i < NUM_CH; i++) begin
                if (frame_end_c)         wr_cnt_q[i] <= '0;
                else if (wr_accept_c[i]) wr_cnt_q[i] <= wr_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Map storage has no reset; rejected writes never reach it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_accept_c[i]) mem_q[i][wr_cnt_q[i]] <= bus.wr_pixel[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ds_start_q   <= 1'b0;
            valid_q      <= 1'b0;
            pixel_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            ds_start_q   <= (state_d == ST_START);
            valid_q      <= issue_c;
            busy_q       <= (state_d != ST_FILL);
            frame_done_q <= frame_end_c;
            overflow_q   <= overflow_q | (|(bus.wr_valid & ~wr_accept_c));
            if (issue_c) begin
                for (int i = 0; i < NUM_CH; i++) pixel_q[i*8 +: 8] <= mem_q[i][rd_addr_q];
            end
        end
    end

    assign bus.ds_start       = ds_start_q;
    assign bus.data_valid_out = {NUM_CH{valid_q}};
    assign bus.pixel_out      = pixel_q;
    assign bus.busy           = busy_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.overflow       = overflow_q;
endmodule
